hq_tod_serializer: RTL and testbench

//  Downstream consumer of the binary-to-BCD converter in the HaveQuick TOD path.

---
 rtl/hq_tod_serializer_pkg.sv | 35 +++
 rtl/hq_tod_serializer_if.sv | 33 +++
 rtl/hq_tod_serializer_half_bit_timer.sv | 37 +++
 rtl/hq_tod_serializer.sv | 162 ++++++++++++++++
 tb/tb_hq_tod_serializer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/hq_tod_serializer_pkg.sv
// Shared types and helpers for the HaveQuick TOD serializer: state encoding,
// Manchester half-bit patterns and a constant clog2.
package hq_tod_serializer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // {first half, second half} of a Manchester bit cell
    localparam logic [1:0] MANCH_ONE  = 2'b10;
    localparam logic [1:0] MANCH_ZERO = 2'b01;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    function automatic state_t next_field(input state_t s);
        case (s)
            ST_SYNC:   return ST_DATA;
            ST_DATA:   return ST_PARITY;
            ST_PARITY: return ST_DONE;
            default:   return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/hq_tod_serializer_if.sv
// Converter-side bus of the TOD serializer: BCD word and DV in, status and
// Manchester line out.
interface hq_tod_serializer_if #(
    parameter int DECIMAL_DIGITS = 6
);
    logic [DECIMAL_DIGITS*4-1:0] i_BCD;
    logic                        i_DV;
    logic                        o_Ready;
    logic                        o_Busy;
    logic                        o_Serial;
    logic                        o_Frame_Done;
    logic                        o_Error;

    modport master (
        output i_BCD,
        output i_DV,
        input  o_Ready,
        input  o_Busy,
        input  o_Serial,
        input  o_Frame_Done,
        input  o_Error
    );

    modport slave (
        input  i_BCD,
        input  i_DV,
        output o_Ready,
        output o_Busy,
        output o_Serial,
        output o_Frame_Done,
        output o_Error
    );
endinterface

// File: rtl/hq_tod_serializer_half_bit_timer.sv
// Half-bit timer: counts 0..HALF_BIT_CYCLES-1 while running and pulses o_Tick
// on the last cycle of each half-bit; clears whenever i_Run drops.
module hq_tod_serializer_half_bit_timer
    import hq_tod_serializer_pkg::*;
#(
    parameter int HALF_BIT_CYCLES = 4
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Run,
    output logic o_Tick
);

    localparam int CW = (HALF_BIT_CYCLES > 1) ? clog2(HALF_BIT_CYCLES) : 1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          last;

    always_comb begin
        last    = (count_q == CW'(HALF_BIT_CYCLES - 1));
        count_d = '0;
        if (i_Run && !last) begin
            count_d = count_q + CW'(1);
        end
        o_Tick = i_Run && last;
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/hq_tod_serializer.sv
// HaveQuick TOD serializer: captures a BCD hhmmss word on a DV rising edge and
// sends SYNC + BCD + even parity, MSB first, Manchester-encoded on o_Serial.
//
//  state     | meaning
//  ST_IDLE   | waiting for DV rising edge; validates and latches BCD
//  ST_SYNC   | sending SYNC_WORD, MSB first
//  ST_DATA   | sending BCD digits, most significant digit first
//  ST_PARITY | sending XOR of all data bits
//  ST_DONE   | one-cycle frame-complete pulse, then back to idle
module hq_tod_serializer
    import hq_tod_serializer_pkg::*;
#(
    parameter int                    DECIMAL_DIGITS  = 6,
    parameter int                    SYNC_WIDTH      = 16,
    parameter logic [SYNC_WIDTH-1:0] SYNC_WORD       = 16'hEB90,
    parameter int                    HALF_BIT_CYCLES = 4
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    hq_tod_serializer_if.slave    bus
);

    localparam int DATA_W     = DECIMAL_DIGITS * 4;
    localparam int SHIFT_W    = SYNC_WIDTH + DATA_W;
    localparam int FRAME_BITS = SHIFT_W + 1;
    localparam int CNT_W      = clog2(FRAME_BITS + 1);

    state_t             state_q,   state_d;
    logic [SHIFT_W-1:0] shift_q,   shift_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               phase_q,   phase_d;
    logic               parity_q,  parity_d;
    logic               dv_prev_q, dv_prev_d;
    logic               serial_q,  serial_d;
    logic               error_q,   error_d;

    logic               tick;
    logic               running;
    logic               dv_edge;
    logic               bcd_ok;
    logic [CNT_W-1:0]   field_last;
    logic               cur_bit;
    logic [1:0]         manch;

    assign running = (state_q == ST_SYNC) || (state_q == ST_DATA) || (state_q == ST_PARITY);

    hq_tod_serializer_half_bit_timer #(
        .HALF_BIT_CYCLES (HALF_BIT_CYCLES)
    ) u_half_bit_timer (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .i_Run   (running),
        .o_Tick  (tick)
    );

    always_comb begin
        bcd_ok = 1'b1;
        for (int i = 0; i < DECIMAL_DIGITS; i++) begin
            if (bus.i_BCD[i*4 +: 4] > 4'd9) begin
                bcd_ok = 1'b0;
            end
        end
    end

    always_comb begin
        case (state_q)
            ST_SYNC: field_last = CNT_W'(SYNC_WIDTH - 1);
            ST_DATA: field_last = CNT_W'(DATA_W - 1);
            default: field_last = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        phase_d   = phase_q;
        parity_d  = parity_q;
        error_d   = 1'b0;
        dv_prev_d = bus.i_DV;
        dv_edge   = bus.i_DV && !dv_prev_q;

        unique case (state_q)
            ST_IDLE: begin
                if (dv_edge) begin
                    if (bcd_ok) begin
                        state_d   = ST_SYNC;
                        shift_d   = {SYNC_WORD, bus.i_BCD};
                        bit_cnt_d = '0;
                        phase_d   = 1'b0;
                        parity_d  = 1'b0;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            ST_SYNC, ST_DATA, ST_PARITY: begin
                if (tick) begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d   = 1'b0;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        shift_d   = {shift_q[SHIFT_W-2:0], 1'b0};
                        if (state_q == ST_DATA) begin
                            parity_d = parity_q ^ shift_q[SHIFT_W-1];
                        end
                        if (bit_cnt_q == field_last) begin
                            bit_cnt_d = '0;
                            state_d   = next_field(state_q);
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Line level is computed from next-cycle state so o_Serial stays registered
        // yet the first SYNC half-bit lands the cycle right after the accept.
        cur_bit  = (state_d == ST_PARITY) ? parity_d : shift_d[SHIFT_W-1];
        manch    = cur_bit ? MANCH_ONE : MANCH_ZERO;
        serial_d = 1'b0;
        if ((state_d == ST_SYNC) || (state_d == ST_DATA) || (state_d == ST_PARITY)) begin
            serial_d = phase_d ? manch[0] : manch[1];
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            phase_q   <= 1'b0;
            parity_q  <= 1'b0;
            serial_q  <= 1'b0;
            error_q   <= 1'b0;
            // Track the live DV level so a DV held through reset is not seen as an edge.
            dv_prev_q <= bus.i_DV;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            phase_q   <= phase_d;
            parity_q  <= parity_d;
            serial_q  <= serial_d;
            error_q   <= error_d;
            dv_prev_q <= dv_prev_d;
        end
    end

    assign bus.o_Ready      = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign bus.o_Busy       = running;
    assign bus.o_Serial     = serial_q;
    assign bus.o_Frame_Done = (state_q == ST_DONE);
    assign bus.o_Error      = error_q;

endmodule

// File: tb/tb_hq_tod_serializer.sv
// Self-checking bench for hq_tod_serializer: frame waveform compared cycle by
// cycle against a bit-list model, plus a Manchester decoder on the captured line.
module tb_hq_tod_serializer;

    localparam int          DD    = 6;
    localparam int          SW    = 16;
    localparam int          HB    = 4;
    localparam logic [15:0] SWORD = 16'hEB90;
    localparam int          DW    = DD * 4;
    localparam int          NB    = SW + DW + 1;
    localparam int          FC    = 2 * NB * HB;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hq_tod_serializer_if #(.DECIMAL_DIGITS(DD)) bus ();

    hq_tod_serializer #(
        .DECIMAL_DIGITS  (DD),
        .SYNC_WIDTH      (SW),
        .SYNC_WORD       (SWORD),
        .HALF_BIT_CYCLES (HB)
    ) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int   n_checks  = 0;
    int   n_fail    = 0;
    int   done_seen = 0;
    int   err_seen  = 0;
    logic wave [1:FC];

    always @(negedge clk) begin
        if (bus.o_Frame_Done === 1'b1) done_seen++;
        if (bus.o_Error === 1'b1) err_seen++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Frame as a list of bits, first-sent at the MSB
    function automatic logic [NB-1:0] model_frame(input logic [DW-1:0] bcd);
        return {SWORD, bcd, ^bcd};
    endfunction

    // Expected line level k cycles after the accept (k = 1 .. FC)
    function automatic logic exp_level(input logic [NB-1:0] frame, input int k);
        int   half;
        logic v;
        half = (k - 1) / HB;
        v    = frame[NB - 1 - half / 2];
        return (half % 2 == 0) ? v : ~v;
    endfunction

    function automatic logic [DW-1:0] rand_bcd();
        logic [DW-1:0] b;
        for (int i = 0; i < DD; i++) b[i*4 +: 4] = 4'($urandom_range(0, 9));
        return b;
    endfunction

    // Reference Manchester decoder over the captured waveform
    function automatic logic [NB-1:0] decode_wave();
        logic [NB-1:0] d;
        logic          f, s;
        for (int b = 0; b < NB; b++) begin
            f = wave[2*b*HB + 1];
            s = wave[(2*b+1)*HB + 1];
            if (f === 1'b1 && s === 1'b0)      d[NB-1-b] = 1'b1;
            else if (f === 1'b0 && s === 1'b1) d[NB-1-b] = 1'b0;
            else                               d[NB-1-b] = 1'bx;
        end
        return d;
    endfunction

    // Caller guarantees i_DV was low in the previous cycle.
    task automatic run_frame(input string tag, input logic [DW-1:0] bcd,
                             input bit hold_dv, input int glitch_at);
        logic [NB-1:0] frame;
        int            d0;
        frame = model_frame(bcd);
        d0    = done_seen;
        bus.i_BCD = bcd;
        bus.i_DV  = 1'b1;
        cyc(1);
        chk({tag, ".busy_t1"}, bus.o_Busy, 1'b1);
        chk({tag, ".ready_t1"}, bus.o_Ready, 1'b0);
        for (int k = 1; k <= FC; k++) begin
            wave[k] = bus.o_Serial;
            chk($sformatf("%s.serial@%0d", tag, k), bus.o_Serial, exp_level(frame, k));
            if (!hold_dv && k == 10) bus.i_DV = 1'b0;
            if (glitch_at > 0 && k == glitch_at) begin
                bus.i_DV  = 1'b1;
                bus.i_BCD = 24'h235959;
            end
            cyc(1);
        end
        chk({tag, ".done"}, bus.o_Frame_Done, 1'b1);
        chk({tag, ".busy_done"}, bus.o_Busy, 1'b0);
        chk({tag, ".ready_done"}, bus.o_Ready, 1'b1);
        chk({tag, ".serial_done"}, bus.o_Serial, 1'b0);
        cyc(1);
        chk({tag, ".done_after"}, bus.o_Frame_Done, 1'b0);
        chk({tag, ".done_count"}, done_seen - d0, 1);
        chk({tag, ".decoded"}, decode_wave(), frame);
    endtask

    task automatic run_invalid(input string tag, input logic [DW-1:0] bcd);
        int e0;
        int busy_or_line;
        e0 = err_seen;
        busy_or_line = 0;
        bus.i_BCD = bcd;
        bus.i_DV  = 1'b1;
        cyc(1);
        chk({tag, ".error_t1"}, bus.o_Error, 1'b1);
        chk({tag, ".ready_t1"}, bus.o_Ready, 1'b1);
        chk({tag, ".busy_t1"}, bus.o_Busy, 1'b0);
        cyc(1);
        chk({tag, ".error_t2"}, bus.o_Error, 1'b0);
        for (int k = 0; k < 400; k++) begin
            if (bus.o_Serial !== 1'b0 || bus.o_Ready !== 1'b1) busy_or_line++;
            if (k == 5) bus.i_DV = 1'b0;
            cyc(1);
        end
        chk({tag, ".quiet_cycles"}, busy_or_line, 0);
        chk({tag, ".error_count"}, err_seen - e0, 1);
    endtask

    initial begin
        logic [DW-1:0] b;
        int            d0;
        int            pos;

        bus.i_BCD = '0;
        bus.i_DV  = 1'b0;
        rst       = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(1);
        chk("reset.ready", bus.o_Ready, 1'b1);
        chk("reset.busy", bus.o_Busy, 1'b0);
        chk("reset.serial", bus.o_Serial, 1'b0);
        chk("reset.done", bus.o_Frame_Done, 1'b0);
        chk("reset.error", bus.o_Error, 1'b0);

        run_frame("t1_123456", 24'h123456, 1'b0, 0);
        cyc(3);

        run_invalid("t2_12A456", 24'h12A456);
        cyc(2);

        d0 = done_seen;
        run_frame("t3_sticky", rand_bcd(), 1'b1, 0);
        cyc(1000 - FC - 2);
        chk("t3.busy_end", bus.o_Busy, 1'b0);
        chk("t3.one_frame", done_seen - d0, 1);
        bus.i_DV = 1'b0;
        cyc(2);

        d0 = done_seen;
        run_frame("t4_glitch", 24'h104512, 1'b0, 50);
        cyc(20);
        chk("t4.no_second_busy", bus.o_Busy, 1'b0);
        chk("t4.no_second_done", done_seen - d0, 1);
        bus.i_DV = 1'b0;
        cyc(2);

        bus.i_BCD = 24'h095959;
        bus.i_DV  = 1'b1;
        cyc(1);
        for (int k = 1; k < 100; k++) begin
            if (k == 10) bus.i_DV = 1'b0;
            cyc(1);
        end
        rst = 1'b1;
        cyc(1);
        chk("t5.serial", bus.o_Serial, 1'b0);
        chk("t5.busy", bus.o_Busy, 1'b0);
        chk("t5.ready", bus.o_Ready, 1'b1);
        rst = 1'b0;
        cyc(2);
        run_frame("t5_fresh", rand_bcd(), 1'b0, 0);
        cyc(2);

        run_frame("t6_zero", 24'h000000, 1'b0, 0);
        chk("t6.parity", wave[FC - 2*HB + 1], 1'b0);
        cyc(2);

        // DV asserted together with reset and held: must not start a frame
        rst       = 1'b1;
        bus.i_DV  = 1'b1;
        bus.i_BCD = 24'h111111;
        cyc(2);
        rst = 1'b0;
        cyc(5);
        chk("rst_dv.busy", bus.o_Busy, 1'b0);
        chk("rst_dv.ready", bus.o_Ready, 1'b1);
        bus.i_DV = 1'b0;
        cyc(2);

        for (int r = 0; r < 4; r++) begin
            run_frame($sformatf("rand_%0d", r), rand_bcd(), 1'b0, 0);
            cyc($urandom_range(1, 6));
        end

        for (int r = 0; r < 3; r++) begin
            b   = rand_bcd();
            pos = $urandom_range(0, DD - 1);
            b[pos*4 +: 4] = 4'($urandom_range(10, 15));
            run_invalid($sformatf("rand_bad_%0d", r), b);
            cyc(2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
